// File: rtl/reset_sequencer.sv
// Board reset sequencer: arbitrates latched reset requests, records the first
// cause and drives the board reset through hold / wait-release / settle.
module reset_sequencer #(
    parameter int unsigned          NUM_SRC      = 4,
    parameter int unsigned          CNT_WIDTH    = 8,
    parameter logic [CNT_WIDTH-1:0] HOLD_TICKS   = CNT_WIDTH'(10),
    parameter logic [CNT_WIDTH-1:0] SETTLE_TICKS = CNT_WIDTH'(4)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic [NUM_SRC-1:0] req,
    input  logic [NUM_SRC-1:0] req_mask,
    input  logic               cause_clr,
    output logic               reset_out_n,
    output logic               busy,
    output logic [NUM_SRC-1:0] ack,
    output logic [NUM_SRC-1:0] cause,
    output logic               cause_valid
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ASSERT   = 2'd1;
    localparam logic [1:0] ST_WAIT_REL = 2'd2;
    localparam logic [1:0] ST_SETTLE   = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 reset_out_n_q, reset_out_n_d;
    logic                 busy_q, busy_d;
    logic [NUM_SRC-1:0]   ack_q, ack_d;
    logic [NUM_SRC-1:0]   cause_q, cause_d;
    logic                 cause_valid_q, cause_valid_d;

    logic [NUM_SRC-1:0]   act_c;
    logic [NUM_SRC-1:0]   lowest_c;

    // Enabled requests and their highest-priority (lowest index) member.
    always_comb begin
        act_c    = req & req_mask;
        lowest_c = act_c & (~act_c + NUM_SRC'(1));
    end

    // Next-state, counter, cause capture and registered-output precompute.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ack_d         = '0;
        cause_d       = cause_q;
        cause_valid_d = cause_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (act_c != '0) begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                end
            end
            ST_ASSERT: begin
                // Hold length depends only on ticks, never on requests.
                if (cnt_q == HOLD_TICKS) begin
                    state_d = ST_WAIT_REL;
                    ack_d   = act_c;
                end else if (ce) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            ST_WAIT_REL: begin
                if (act_c == '0) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_TICKS) begin
                    state_d = ST_IDLE;
                end else if (ce) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_ASSERT;
                cnt_d   = '0;
            end
        endcase

        // A capture in IDLE beats a simultaneous clear; otherwise clear wins.
        if ((state_q == ST_IDLE) && (act_c != '0) && (!cause_valid_q || cause_clr)) begin
            cause_d       = lowest_c;
            cause_valid_d = 1'b1;
        end else if (cause_clr) begin
            cause_d       = '0;
            cause_valid_d = 1'b0;
        end

        reset_out_n_d = (state_d == ST_IDLE) || (state_d == ST_SETTLE);
        busy_d        = (state_d != ST_IDLE);
    end

    // State and output registers; reset starts a full power-on sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_ASSERT;
            cnt_q         <= '0;
            reset_out_n_q <= 1'b0;
            busy_q        <= 1'b1;
            ack_q         <= '0;
            cause_q       <= '0;
            cause_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            reset_out_n_q <= reset_out_n_d;
            busy_q        <= busy_d;
            ack_q         <= ack_d;
            cause_q       <= cause_d;
            cause_valid_q <= cause_valid_d;
        end
    end

    assign reset_out_n = reset_out_n_q;
    assign busy        = busy_q;
    assign ack         = ack_q;
    assign cause       = cause_q;
    assign cause_valid = cause_valid_q;

endmodule
